// File: rtl/mix_sched_pkg.sv
// Shared constants, stage/state encodings and operand offsets for the
// time-multiplexed eight-lane mixing sequencer.
package mix_sched_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {S0, S1, S2, S3} stage_e;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [IDX_W-1:0] OFF_S1   = 3'd7;
  localparam logic [IDX_W-1:0] OFF_S2_B = 3'd1;
  localparam logic [IDX_W-1:0] OFF_S2_C = 3'd5;
  localparam logic [IDX_W-1:0] OFF_S3   = 3'd3;
  localparam int               SHIFT    = 16;

  // Offset of the 'b' operand lane relative to the lane being updated.
  function automatic logic [IDX_W-1:0] b_offset(input stage_e st);
    case (st)
      S1:      return OFF_S1;
      S2:      return OFF_S2_B;
      S3:      return OFF_S3;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mix_lane_alu.sv
// Shared combinational lane ALU: computes one in-place lane update for the
// given stage from a = o[i] and the stage-specific neighbour operands b, c.
module mix_lane_alu
  import mix_sched_pkg::*;
(
  input  stage_e             stage,
  input  logic [IDX_W-1:0]   lane,
  input  logic [LANE_W-1:0]  a,
  input  logic [LANE_W-1:0]  b,
  input  logic [LANE_W-1:0]  c,
  output logic [LANE_W-1:0]  result
);

  always_comb begin
    result = a;
    case (stage)
      S0:      result = a + LANE_W'(lane);
      S1:      result = a + b;
      S2:      result = a + b - c;
      S3:      result = a ^ (b << SHIFT);
      default: result = a;
    endcase
  end

endmodule

// File: rtl/mix_lane_scheduler.sv
// Eight-lane mixing sequencer: one shared ALU, one lane update per clock,
// four stages x eight lanes per round, ROUNDS rounds per start.
module mix_lane_scheduler
  import mix_sched_pkg::*;
#(
  parameter int ROUNDS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [LANE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LANE_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_t                        state_reg, state_next;
  stage_e                        stage_reg;
  logic [IDX_W-1:0]              lane_reg;
  logic [RND_W-1:0]              round_reg;
  logic [LANES-1:0][LANE_W-1:0]  o_cur;
  logic [IDX_W-1:0]              b_idx, c_idx;
  logic [LANE_W-1:0]             alu_result;
  logic                          last_update;
  logic                          run_en, idle_wr;

  assign run_en      = (state_reg == RUN);
  assign idle_wr     = (state_reg == IDLE) && wr_en;
  assign last_update = (stage_reg == S3) && (lane_reg == 3'd7) &&
                       (round_reg == RND_W'(ROUNDS - 1));

  // Operand lanes wrap mod 8 through the natural 3-bit overflow.
  assign b_idx = lane_reg + b_offset(stage_reg);
  assign c_idx = lane_reg + OFF_S2_C;

  mix_lane_alu u_alu (
    .stage  (stage_reg),
    .lane   (lane_reg),
    .a      (o_cur[lane_reg]),
    .b      (o_cur[b_idx]),
    .c      (o_cur[c_idx]),
    .result (alu_result)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] val_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          val_reg <= LANE_W'(gi);
        else if (run_en && lane_reg == IDX_W'(gi))
          val_reg <= alu_result;
        else if (idle_wr && wr_idx == IDX_W'(gi))
          val_reg <= wr_data;
      end
      assign o_cur[gi] = val_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_update) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      stage_reg <= S0;
      lane_reg  <= '0;
      round_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        stage_reg <= S0;
        lane_reg  <= '0;
        round_reg <= '0;
      end else if (run_en) begin
        lane_reg <= lane_reg + 3'd1;
        if (lane_reg == 3'd7) begin
          stage_reg <= stage_e'(stage_reg + 2'd1);
          if (stage_reg == S3)
            round_reg <= round_reg + 1'b1;
        end
      end
    end
  end

  assign rd_data = o_cur[rd_idx];
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);

endmodule

// File: doc/mix_lane_scheduler.md
# mix_lane_scheduler

Time-multiplexed sequencer for the eight-lane 32-bit mixing datapath. It holds the eight lane registers `o0..o7` and shares one 32-bit lane ALU across them, applying one lane update per clock. Each round is four in-place stages × eight lanes, and the block runs `ROUNDS` rounds per start request. It replaces the fully unrolled per-edge mixing update when area matters more than throughput.

## Interface
- `ROUNDS`, default 1: rounds executed per start, ≥1.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous reset, active-high.
- `start  in  1`: begin a run. Sampled only in IDLE.
- `wr_en  in  1`: lane write strobe. Honoured only in IDLE.
- `wr_idx  in  3`: lane to write.
- `wr_data  in  32`: value to write.
- `rd_idx  in  3`: lane to read.
- `rd_data  out  32`: combinational read, `o[rd_idx]`.
- `busy  out  1`: high while in RUN.
- `done  out  1`: one-cycle pulse when a run completes.

## Operation
- Lane registers `o[0..7]`, 32 bits each. Reset value is `o[i] = i`. `busy` and `done` reset to 0.
- Stage definitions. In every stage lanes are processed in order i = 0..7, and all indices are mod 8:
  - S0: `o[i] = o[i] + i`
  - S1: `o[i] = o[i] + o[i+7]`
  - S2: `o[i] = o[i] + o[i+1] - o[i+5]`
  - S3: `o[i] = o[i] ^ (o[i+3] << 16)`
- In-place semantics: a lane update reads the current register contents. Lanes written earlier in the same stage are therefore seen by later lanes (e.g. S1 lane 1 reads the new `o[0]`).
- Arithmetic is 32-bit modulo 2^32 with no saturation. `<<` is logical and discards the upper bits.
- FSM has three states:
  - IDLE: `wr_en` writes `o[wr_idx]`. On `start`, go to RUN with lane=0, stage=S0, round=0. If `start` and `wr_en` occur in the same cycle, the write lands first and the run uses the written value.
  - RUN: one lane update per cycle. lane increments 0..7. When lane wraps, stage advances S0→S3. When the stage wraps, round increments. After round `ROUNDS-1`, stage S3, lane 7, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` and `wr_en` are ignored (no effect, not queued) in RUN and DONE.
- `rst` in any state forces IDLE, clears all counters, restores `o[i]=i`, and drops `busy`/`done` immediately.

## Timing
- Start accepted at edge N. `busy`=1 from after edge N through the last update at edge N+32·ROUNDS.
- DONE is entered after edge N+32·ROUNDS. In that cycle `done`=1, `busy`=0, and `rd_data` already shows final values.
- Back in IDLE after edge N+32·ROUNDS+1, so a new `start` can be accepted at that edge.
- `rd_data` has zero latency and always reflects register state, including mid-run.
- Writes take effect at the edge where `wr_en` is sampled.

## Structure
- Package `mix_sched_pkg` holds:
  - `LANES` = 8 and the lane width of 32.
  - The stage enum (S0..S3) and the state enum (IDLE/RUN/DONE).
  - Per-stage operand offsets: S1 {7}, S2 {1,5}, S3 {3}, and the shift amount 16.
- Sub-module `mix_lane_alu` is combinational. Inputs are stage, lane index, `a=o[i]`, `b`, and `c`; output is the 32-bit result.
- The top level owns the register file, the operand muxing by lane+offset, the counters, and the FSM.

## Test plan
- Reset, then `start`, with `ROUNDS`=1 → `done` pulses 33 cycles after start. Read-back values:
  - `o0=0xFFB5FFF2`, `o1=0xFF9DFFEC`, `o2=0xFF83FFE8`, `o3=0x0034004A`
  - `o4=0xFFD60062`, `o5=0xFFF2007C`, `o6=0xFFEC0034`, `o7=0x0017FFD6`
- Probe mid-run from reset values → after S1 completes, the lanes read 14,16,20,26,34,44,56,70. After S2 completes, `o0=0xFFFFFFF2` and `o3=74`.
- Pulse `start` and `wr_en` (lane 2, 0xDEADBEEF) at cycle 5 of a run → no restart, `o2` unaffected by the write, `done` still occurs at cycle 33.
- Assert `rst` at cycle 17 of a run → `busy`=0 and `done`=0 immediately, lanes read 0..7, and no `done` pulse follows.
- With `ROUNDS`=2, write all lanes 0 then `start` → `busy` high for 64 cycles and a single `done` pulse. Result must equal the value obtained by applying the spec round function twice to the zero vector.
- Assert `start` together with `wr_en` (lane 0, 0x7) in IDLE → the run uses `o0`=7. Also assert `start` in the cycle `done` is high → it is ignored, and `start` on the following cycle is accepted.
